// File: rtl/rr_arbiter_quantum.sv
// Round-robin arbiter for N requesters with a programmable grant slice,
// per-requester mask, early release on request drop and a slice-expiry pulse.
module rr_arbiter_quantum #(
    parameter int N  = 4,
    parameter int QW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic [QW-1:0]        quantum,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 expire
);
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] rel_ptr, pick_start, pick_idx;
    logic [QW-1:0] cnt, cnt_n;
    logic [QW-1:0] q, q_n, q_in;
    logic [N-1:0]  elig;
    logic          pick_found, rel, expire_n;

    assign elig    = req & ~mask;
    assign q_in    = (quantum == '0) ? QW'(1) : quantum;
    assign rel_ptr = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
    // On release the search starts just past the owner, so the owner is considered last.
    assign pick_start = (state == GRANT) ? rel_ptr : ptr;
    assign rel = ~req[owner] | mask[owner] | (cnt == q - 1'b1);

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!pick_found && elig[(int'(pick_start) + i) % N]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(pick_start) + i) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            ptr    <= '0;
            cnt    <= '0;
            q      <= '0;
            expire <= 1'b0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            q      <= q_n;
            expire <= expire_n;
        end
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        ptr_n    = ptr;
        cnt_n    = cnt;
        q_n      = q;
        expire_n = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = GRANT;
                    owner_n = pick_idx;
                    cnt_n   = '0;
                    q_n     = q_in;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_n = rel_ptr;
                    // Owner still wants the resource, so the slice ran out.
                    expire_n = req[owner] & ~mask[owner];
                    cnt_n    = '0;
                    if (pick_found) begin
                        owner_n = pick_idx;
                        q_n     = q_in;
                    end else begin
                        state_n = IDLE;
                        owner_n = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        if (state == GRANT) begin
            gnt       = N'(1) << owner;
            gnt_valid = 1'b1;
            gnt_id    = owner;
        end
    end
endmodule
